fc_argmax: RTL and testbench

Classification stage placed directly after the fully connected layer. Samples the stream of `OUTPUT_NUM` signed class scores, one per `valid_in` pulse, and tracks the running maximum. After the last score of a frame it emits the winning class index with a one-cycle valid strobe. Optionally it also reports the winning score and the margin over the runner-up as a confidence measure.

---
 rtl/fc_argmax_if.sv | 27 ++
 rtl/fc_argmax.sv | 100 ++++++++++
 tb/tb_fc_argmax.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fc_argmax_if.sv
// rtl/fc_argmax_if.sv - score stream in / decision out bundle for fc_argmax (FC_ARGMAX_MARGIN_EN adds best_score/margin)
interface fc_argmax_if #(
    parameter int DATA_WIDTH = 12,
    parameter int IDX_WIDTH  = 4
) ();
    logic                         valid_in;
    logic signed [DATA_WIDTH-1:0] data_in;
    logic                         frame_clr;
    logic [IDX_WIDTH-1:0]         decision;
    logic                         valid_out;
    logic                         busy;
    logic [7:0]                   frame_cnt;
`ifdef FC_ARGMAX_MARGIN_EN
    logic signed [DATA_WIDTH-1:0] best_score;
    logic [DATA_WIDTH-1:0]        margin;

    modport master (output valid_in, data_in, frame_clr,
                    input  decision, valid_out, busy, frame_cnt, best_score, margin);
    modport slave  (input  valid_in, data_in, frame_clr,
                    output decision, valid_out, busy, frame_cnt, best_score, margin);
`else
    modport master (output valid_in, data_in, frame_clr,
                    input  decision, valid_out, busy, frame_cnt);
    modport slave  (input  valid_in, data_in, frame_clr,
                    output decision, valid_out, busy, frame_cnt);
`endif
endinterface

// File: rtl/fc_argmax.sv
// rtl/fc_argmax.sv - running argmax over OUTPUT_NUM signed class scores; FC_ARGMAX_MARGIN_EN adds best score and runner-up margin
module fc_argmax #(
    parameter int OUTPUT_NUM = 10,
    parameter int DATA_WIDTH = 12,
    parameter int IDX_WIDTH  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    fc_argmax_if.slave  bus
);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(OUTPUT_NUM - 1);

    logic [IDX_WIDTH-1:0]         cnt, run_idx, win_idx, decision_q;
    logic signed [DATA_WIDTH-1:0] run_val, win_val;
    logic                         first, gt, is_last;
    logic                         valid_q, busy_q;
    logic [7:0]                   frame_q;

    // Winner including the current sample; on the last score it goes straight to the outputs.
    always_comb begin
        first   = (cnt == '0);
        is_last = (cnt == LAST_IDX);
        gt      = (bus.data_in > run_val);
        win_val = (first || gt) ? bus.data_in : run_val;
        win_idx = first ? '0 : (gt ? cnt : run_idx);
    end

`ifdef FC_ARGMAX_MARGIN_EN
    localparam logic signed [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic signed [DATA_WIDTH-1:0] run_2nd, win_2nd, best_q;
    logic [DATA_WIDTH-1:0]        margin_w, margin_q;

    always_comb begin
        if (first)
            win_2nd = MIN_VAL;
        else if (gt)
            win_2nd = run_val;
        else if (bus.data_in > run_2nd)
            win_2nd = bus.data_in;
        else
            win_2nd = run_2nd;
        // best >= runner-up, so the modulo-2^DATA_WIDTH difference is the exact margin
        margin_w = win_val - win_2nd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_2nd  <= '0;
            best_q   <= '0;
            margin_q <= '0;
        end else if (!bus.frame_clr && bus.valid_in) begin
            run_2nd <= win_2nd;
            if (is_last) begin
                best_q   <= win_val;
                margin_q <= margin_w;
            end
        end
    end

    assign bus.best_score = best_q;
    assign bus.margin     = margin_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            run_val    <= '0;
            run_idx    <= '0;
            decision_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            frame_q    <= '0;
        end else begin
            valid_q <= 1'b0;
            if (bus.frame_clr) begin
                cnt    <= '0;
                busy_q <= 1'b0;
            end else if (bus.valid_in) begin
                run_val <= win_val;
                run_idx <= win_idx;
                if (is_last) begin
                    cnt        <= '0;
                    busy_q     <= 1'b0;
                    decision_q <= win_idx;
                    valid_q    <= 1'b1;
                    frame_q    <= frame_q + 8'd1;
                end else begin
                    cnt    <= cnt + IDX_WIDTH'(1);
                    busy_q <= 1'b1;
                end
            end
        end
    end

    assign bus.decision  = decision_q;
    assign bus.valid_out = valid_q;
    assign bus.busy      = busy_q;
    assign bus.frame_cnt = frame_q;
endmodule

// File: tb/tb_fc_argmax.sv
// tb/tb_fc_argmax.sv - randomized self-checking bench for fc_argmax against a frame-level argmax model
module tb_fc_argmax;
    localparam int N  = 10;
    localparam int DW = 12;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fc_argmax_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) bus ();

    fc_argmax #(.OUTPUT_NUM(N), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int pass_cnt = 0;
    int total    = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    // Frame-level model: collect a frame, then argmax / runner-up over the whole array.
    int q[$];
    int m_dec = 0, m_cnt = 0, m_best = 0, m_margin = 0;
    bit m_valid = 1'b0, m_busy = 1'b0;
    int bi, sec;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_dec = 0; m_cnt = 0; m_best = 0; m_margin = 0;
            m_valid = 1'b0; m_busy = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (bus.frame_clr) begin
                q.delete();
            end else if (bus.valid_in) begin
                q.push_back(int'(bus.data_in));
                if (q.size() == N) begin
                    bi = 0;
                    for (int i = 1; i < N; i++)
                        if (q[i] > q[bi]) bi = i;
                    sec = -(1 << (DW - 1));
                    for (int i = 0; i < N; i++)
                        if (i != bi && q[i] > sec) sec = q[i];
                    m_dec    = bi;
                    m_best   = q[bi];
                    m_margin = (q[bi] - sec) & ((1 << DW) - 1);
                    m_valid  = 1'b1;
                    m_cnt    = (m_cnt + 1) % 256;
                    q.delete();
                end
            end
            m_busy = (q.size() != 0);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid_out", int'(bus.valid_out), int'(m_valid));
            chk("busy", int'(bus.busy), int'(m_busy));
            chk("frame_cnt", int'(bus.frame_cnt), m_cnt);
            chk("decision", int'(bus.decision), m_dec);
`ifdef FC_ARGMAX_MARGIN_EN
            chk("best_score", int'(bus.best_score), m_best);
            chk("margin", int'(bus.margin), m_margin);
`endif
        end
    end

    int fr[N];

    task automatic drive(input bit v, input int d, input bit c);
        bus.valid_in  = v;
        bus.data_in   = DW'(d);
        bus.frame_clr = c;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 1'b0);
    endtask

    task automatic send_frame(input int gap);
        for (int i = 0; i < N; i++) begin
            drive(1'b1, fr[i], 1'b0);
            if (i < N - 1) idle(gap);
        end
        bus.valid_in = 1'b0;
    endtask

    function automatic int rnd_score(input bit narrow);
        if (narrow) return int'($urandom_range(0, 3)) - 2;
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    int done;

    initial begin
        bus.valid_in = 1'b0; bus.data_in = '0; bus.frame_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_decision", int'(bus.decision), 0);
        chk("rst_valid", int'(bus.valid_out), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_frame_cnt", int'(bus.frame_cnt), 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        fr = '{5, -3, 100, 7, 100, 0, -2048, 2047, 2047, 12};
        send_frame(0);
        chk("t1_valid", int'(bus.valid_out), 1);
        chk("t1_decision", int'(bus.decision), 7);
        chk("t1_frame_cnt", int'(bus.frame_cnt), 1);
`ifdef FC_ARGMAX_MARGIN_EN
        chk("t1_best", int'(bus.best_score), 2047);
        chk("t1_margin", int'(bus.margin), 0);
`endif
        idle(1);
        chk("t1_strobe_width", int'(bus.valid_out), 0);

        fr = '{-2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048};
        send_frame(0);
        chk("t2_decision", int'(bus.decision), 0);
`ifdef FC_ARGMAX_MARGIN_EN
        chk("t2_margin", int'(bus.margin), 0);
`endif
        idle(2);

        fr = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        send_frame(3);
        chk("t3_decision", int'(bus.decision), 9);
        chk("t3_busy_at_strobe", int'(bus.busy), 0);
`ifdef FC_ARGMAX_MARGIN_EN
        chk("t3_margin", int'(bus.margin), 1);
`endif
        idle(1);

        for (int i = 0; i < 4; i++) drive(1'b1, 500 + i, 1'b0);
        drive(1'b1, 1000, 1'b1);
        chk("t4_abort_busy", int'(bus.busy), 0);
        chk("t4_abort_no_strobe", int'(bus.valid_out), 0);
        fr = '{1, 2, 300, -5, 299, 0, 300, -100, 4, 7};
        send_frame(0);
        chk("t4_decision", int'(bus.decision), 2);
        chk("t4_frame_cnt", int'(bus.frame_cnt), 4);

        fr = '{10, 20, 30, 40, 900, 50, 60, 70, 80, 90};
        send_frame(0);
        chk("t5a_decision", int'(bus.decision), 4);
        fr = '{-1, -2, -3, -4, -5, -6, 44, -8, 43, 44};
        send_frame(0);
        chk("t5b_valid", int'(bus.valid_out), 1);
        chk("t5b_decision", int'(bus.decision), 6);
        chk("t5b_frame_cnt", int'(bus.frame_cnt), 6);

        for (int i = 0; i < 5; i++) drive(1'b1, 1500 - i, 1'b0);
        bus.valid_in = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_decision", int'(bus.decision), 0);
        chk("t6_rst_frame_cnt", int'(bus.frame_cnt), 0);
        chk("t6_rst_busy", int'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        fr = '{-50, 3, 3, 600, 5, 599, -2048, 2047 - 1500, 0, 12};
        send_frame(1);
        chk("t6_decision", int'(bus.decision), 3);
        chk("t6_frame_cnt", int'(bus.frame_cnt), 1);

        done = 1;
        while (done < 256) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int i = $urandom_range(0, N - 1); i > 0; i--) drive(1'b1, rnd_score(1'b0), 1'b0);
                drive(1'(($urandom_range(0, 1))), rnd_score(1'b0), 1'b1);
            end
            begin
                bit narrow;
                narrow = ($urandom_range(0, 3) == 0);
                for (int i = 0; i < N; i++) fr[i] = rnd_score(narrow);
            end
            send_frame($urandom_range(0, 1) == 0 ? 0 : int'($urandom_range(1, 2)));
            done++;
            if (done == 256) begin
                chk("wrap_valid", int'(bus.valid_out), 1);
                chk("wrap_frame_cnt", int'(bus.frame_cnt), 0);
            end
        end
        idle(3);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
